mem_responder: RTL and testbench

Responder end of the CPU data-memory interface: a word-organised data memory that services one load/store request at a time over a valid/ready request channel and a valid/ready response channel. It inserts a configurable number of wait states, commits each write exactly once, and flags out-of-range accesses. It sits between the multi-cycle CPU's MEM-stage request logic and the memory array, replacing the zero-latency combinational data memory so the CPU's MEM state can stall on a handshake.

---
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-organised data memory behind valid/ready request and response channels, with programmable wait states.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN rejects misaligned (addr[1:0] != 0) accesses.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic          req_ready_r;
  logic          resp_valid_r;
  logic [31:0]   resp_rdata_r;
  logic          resp_err_r;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          out_of_range_s;
  logic          misalign_s;
  logic          err_s;
  logic [AW-1:0] idx_s;

  // Address decode of the latched request: anything above the array is an error.
  assign out_of_range_s = |addr_r[31:AW+2];
  assign misalign_s     = |addr_r[1:0];
  assign err_s          = out_of_range_s | (ALIGN_EN & misalign_s);
  assign idx_s          = addr_r[AW+1:2];

  // Transaction FSM, request latch, commit and memory array in one sequential block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            cnt_r       <= 4'(WAIT_CYCLES);
            req_ready_r <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            // Commit edge: the only place the array is written, so each store lands once.
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            if (err_s) begin
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
            end else if (we_r) begin
              mem_r[idx_s] <= wdata_r;
              resp_err_r   <= 1'b0;
              resp_rdata_r <= 32'd0;
            end else begin
              resp_err_r   <= 1'b0;
              resp_rdata_r <= mem_r[idx_s];
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            resp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [32:0] exp_q [$];   // {err, rdata}
  int          acc_q [$];   // cycle count at accept edge
  logic [31:0] model_mem [DEPTH];
  int rr_random = 0;
  int rr_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: out-of-range (or misaligned with the check) is an error, stores write, loads read.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic bad;
    bad = (addr >= 32'(4 * DEPTH));
`ifdef MEM_RESP_ALIGN_CHECK_EN
    if (addr % 4 != 0) bad = 1'b1;
`endif
    if (bad) return {1'b1, 32'd0};
    if (we) begin
      model_mem[addr / 4] = wdata;
      return {1'b0, 32'd0};
    end
    return {1'b0, model_mem[addr / 4]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    exp_q.delete();
    acc_q.delete();
  endtask

  // Issue one request; returns how many cycles req_ready stayed low afterwards (bounded).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int low);
    int waited;
    waited = 0;
    low = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc_q.push_back(cyc + 1);
    exp_q.push_back(model_access(we, addr, wdata));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom_range(0, 1);
    req_addr = $urandom;
    req_wdata = $urandom;
    @(negedge clk);
    while (!req_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Response-ready driver: random or high, with an optional forced-low hold at the start of each response.
  initial begin
    int low_cnt;
    low_cnt = 0;
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (resp_valid && low_cnt < rr_hold) begin
        resp_ready = 1'b0;
        low_cnt++;
      end else begin
        if (!resp_valid) low_cnt = 0;
        resp_ready = (rr_random != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: checks latency on each new response, holds outputs against the scoreboard head, pops on handshake.
  initial begin
    logic prev_valid;
    int acc;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) begin
            acc = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
            chk("latency", 32'(cyc - acc), 32'(WAITC + 1));
          end
          chk("rdata", resp_rdata, exp_q[0][31:0]);
          chk("err", 32'(resp_err), 32'(exp_q[0][32]));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (resp_ready) void'(exp_q.pop_front());
        end
        prev_valid = resp_valid && !resp_ready;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    int low;
    int nrand;
    logic [31:0] a;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    do_req(1'b0, 32'h10, 32'd0, low);
    do_req(1'b1, 32'h40, 32'hDEADBEEF, low);
    chk("store_busy_cycles", 32'(low), 32'(WAITC + 2));
    do_req(1'b0, 32'h40, 32'd0, low);
    chk("load_busy_cycles", 32'(low), 32'(WAITC + 2));
    drain();

    rr_hold = 5;
    do_req(1'b0, 32'h40, 32'd0, low);
    chk("backpressure_busy_cycles", 32'(low), 32'(WAITC + 2 + 5));
    rr_hold = 0;

    do_req(1'b1, 32'(4 * DEPTH), 32'h12345678, low);
    do_req(1'b0, 32'h0, 32'd0, low);
    do_req(1'b1, 32'h42, 32'hCAFEF00D, low);
    do_req(1'b0, 32'h40, 32'd0, low);
    drain();

    // Store to 0x80 aborted by reset before its commit edge.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h80, 32'd0, low);
    do_req(1'b0, 32'h40, 32'd0, low);
    drain();

    rr_random = 1;
    nrand = 300;
    for (int i = 0; i < nrand; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
        1:       a = $urandom;
        2:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom, low);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
